// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader: byte-stream program loader for the writable instruction memory.
// A stream carries one length byte (word count N), then 4*N little-endian data bytes.
// Each complete word is written to consecutive word addresses starting at 0.
// cpu_hold keeps the processor stalled while a load is in progress or after a failed load.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q;
  logic          in_ready_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic          done_q;
  logic          err_q;

  // Byte lane holds the three lower bytes of the word being assembled;
  // the fourth byte goes straight into the write data.
  logic [1:0]    lane_idx_q;
  logic [23:0]   lane_q;
  logic [AW-1:0] word_idx_q;
  logic [AW-1:0] last_idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    chk_q;
`endif

  // Combinational helpers derived from registered state and the current byte.
  logic          accept_d;
  logic          len_bad_d;
  logic          last_word_d;
  logic [31:0]   word_d;
  logic [AW-1:0] last_idx_d;

  assign accept_d    = in_valid && in_ready_q;
  assign len_bad_d   = (in_data == 8'd0) || ({1'b0, in_data} > 9'(DEPTH));
  assign last_word_d = (word_idx_q == last_idx_q);
  assign word_d      = {in_data, lane_q};
  assign last_idx_d  = AW'(in_data - 8'd1);

  // Loader FSM: stream parsing, word assembly, memory write strobe and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lane_idx_q  <= '0;
      lane_q      <= '0;
      word_idx_q  <= '0;
      last_idx_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      // Strobes default low; they are raised for a single cycle below.
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b0;
          if (start) begin
            state_q    <= S_LEN;
            in_ready_q <= 1'b1;
            err_q      <= 1'b0;
            lane_idx_q <= '0;
            lane_q     <= '0;
            word_idx_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
          end
        end

        S_LEN: begin
          if (accept_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q <= in_data;
`endif
            if (len_bad_d) begin
              // Illegal word count: abort without touching memory.
              err_q      <= 1'b1;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              last_idx_q <= last_idx_d;
              state_q    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q <= chk_q ^ in_data;
`endif
            lane_idx_q <= lane_idx_q + 2'd1;
            case (lane_idx_q)
              2'd0:    lane_q[7:0]   <= in_data;
              2'd1:    lane_q[15:8]  <= in_data;
              2'd2:    lane_q[23:16] <= in_data;
              default: lane_q        <= lane_q;
            endcase
            if (lane_idx_q == 2'd3) begin
              // Fourth byte completes the word; write it next cycle while
              // the stream keeps flowing.
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_idx_q;
              mem_wdata_q <= word_d;
              word_idx_q  <= word_idx_q + AW'(1);
              if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q <= S_CHK;
`else
                in_ready_q <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= S_DONE;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept_d) begin
            // Words are already in memory; a bad checksum only keeps the CPU held.
            if (in_data != chk_q) begin
              err_q <= 1'b1;
            end
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          in_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end

        default: begin
          in_ready_q <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_hold  = (state_q != S_IDLE) || err_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// Testbench for imem_loader: random byte streams checked against a word-level model.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef logic [7:0] byteq_t [$];

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Cycle counter and write/done monitor (sampled on the falling edge).
  int            cyc = 0;
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int            wr_cyc_q  [$];
  int            done_cnt  = 0;
  logic          done_err  = 1'b0;
  int            done_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_err <= err;
      done_cyc <= cyc;
    end
  end

  // ---------------- reference model ----------------
  // Word k of a stream is data bytes 4k..4k+3 (stream index 1+4k..), little-endian.
  function automatic logic [31:0] model_word(input byteq_t s, input int k);
    return {s[4*k+4], s[4*k+3], s[4*k+2], s[4*k+1]};
  endfunction

  function automatic logic model_err(input byteq_t s);
    int n;
    logic [7:0] x;
    n = int'(s[0]);
    x = 8'd0;
    if (n == 0 || n > DEPTH) return 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i <= 4*n; i++) x = x ^ s[i];
    return (s[4*n+1] != x);
`else
    return 1'b0;
`endif
  endfunction

  task automatic make_stream(input int n_len, input int n_words, input bit add_chk,
                             output byteq_t s);
    logic [7:0] x;
    s = {};
    s.push_back(8'(n_len));
    for (int i = 0; i < 4*n_words; i++) s.push_back(8'($urandom));
    x = 8'd0;
    foreach (s[i]) x = x ^ s[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (add_chk) s.push_back(x);
`endif
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // ---------------- stimulus drivers ----------------
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input byteq_t s, input int pct);
    int i;
    int guard;
    bit v;
    bit rdy;
    i = 0;
    guard = 0;
    while (i < s.size()) begin
      @(negedge clk);
      v = ($urandom_range(99) < pct);
      in_valid = v;
      in_data  = v ? s[i] : 8'($urandom);
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) i++;
      guard++;
      if (guard > 2000) begin
        total++; bad++;
        $display("FAIL send_timeout: accepted=%0d required=%0d", i, s.size());
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_load(input byteq_t s, input int pct, input int d0);
    send_bytes(s, pct);
    for (int k = 0; k < 30 && done_cnt == d0; k++) @(posedge clk);
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL done_timeout: done pulses=%0d required>%0d", done_cnt, d0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if (mem_addr !== '0)     begin bad++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    total++; if (cpu_hold !== 1'b0)   begin bad++; $display("FAIL rst_cpu_hold: got %b want 0", cpu_hold); end
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (err !== 1'b0)        begin bad++; $display("FAIL rst_err: got %b want 0", err); end
    reset = 1'b0;
    $display("test_reset: checked reset outputs");
  endtask

  task automatic test_not_ready();
    clear_log();
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h05;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", in_ready); end
    total++; if (wr_addr_q.size() != 0) begin bad++; $display("FAIL idle_writes: got %0d want 0", wr_addr_q.size()); end
    in_valid = 1'b0;
    $display("test_not_ready: idle stream ignored");
  endtask

  task automatic test_single_word();
    byteq_t s;
    int d0;
    s = {8'd1, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s.push_back(8'h12);
`endif
    clear_log();
    d0 = done_cnt;
    pulse_start();
    finish_load(s, 100, d0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      total++; if (wr_addr_q[0] !== 6'd0) begin bad++; $display("FAIL single_addr: got %0d want 0", wr_addr_q[0]); end
      total++; if (wr_data_q[0] !== 32'h00000013) begin bad++; $display("FAIL single_data: got %h want 00000013", wr_data_q[0]); end
    end
    total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL single_done_cnt: got %0d want %0d", done_cnt, d0 + 1); end
    total++; if (done_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", done_err); end
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL single_hold: got %b want 0", cpu_hold); end
    $display("test_single_word: writes=%0d data=%h", wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
  endtask

  task automatic test_back_to_back();
    byteq_t s;
    int d0;
    make_stream(3, 3, 1'b1, s);
    clear_log();
    d0 = done_cnt;
    pulse_start();
    finish_load(s, 100, d0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (wr_addr_q.size() != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", wr_addr_q.size()); end
    for (int k = 0; k < 3 && k < wr_addr_q.size(); k++) begin
      total++; if (wr_addr_q[k] !== AW'(k)) begin bad++; $display("FAIL b2b_addr%0d: got %0d want %0d", k, wr_addr_q[k], k); end
      total++; if (wr_data_q[k] !== model_word(s, k)) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", k, wr_data_q[k], model_word(s, k)); end
      if (k > 0) begin
        total++; if (wr_cyc_q[k] - wr_cyc_q[k-1] != 4) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 4", k, wr_cyc_q[k] - wr_cyc_q[k-1]); end
      end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (wr_cyc_q.size() == 3) begin
      total++; if (done_cyc != wr_cyc_q[2]) begin bad++; $display("FAIL b2b_done_align: got cyc %0d want %0d", done_cyc, wr_cyc_q[2]); end
    end
`endif
    total++; if (done_err !== model_err(s)) begin bad++; $display("FAIL b2b_err: got %b want %b", done_err, model_err(s)); end
    $display("test_back_to_back: writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_bad_len();
    byteq_t s;
    byteq_t g;
    int d0;
    int lens [2] = '{0, 65};
    foreach (lens[j]) begin
      make_stream(lens[j], 0, 1'b0, s);
      clear_log();
      d0 = done_cnt;
      pulse_start();
      finish_load(s, 100, d0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++; if (wr_addr_q.size() != 0) begin bad++; $display("FAIL badlen%0d_writes: got %0d want 0", lens[j], wr_addr_q.size()); end
      total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL badlen%0d_done: got %0d want %0d", lens[j], done_cnt, d0 + 1); end
      total++; if (done_err !== 1'b1) begin bad++; $display("FAIL badlen%0d_err_at_done: got %b want 1", lens[j], done_err); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL badlen%0d_err_sticky: got %b want 1", lens[j], err); end
      total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL badlen%0d_hold: got %b want 1", lens[j], cpu_hold); end
      $display("test_bad_len: N=%0d err=%b hold=%b", lens[j], err, cpu_hold);
    end
    // A following good load clears err on start and releases the CPU.
    make_stream(2, 2, 1'b1, g);
    clear_log();
    d0 = done_cnt;
    pulse_start();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL badlen_err_clear: got %b want 0", err); end
    finish_load(g, 100, d0);
    @(negedge clk);
    total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL badlen_release: got %b want 0", cpu_hold); end
    total++; if (wr_addr_q.size() != 2) begin bad++; $display("FAIL badlen_recover_count: got %0d want 2", wr_addr_q.size()); end
    $display("test_bad_len: recovery load writes=%0d", wr_addr_q.size());
  endtask

  task automatic test_random_valid(input int n_words, input int pct);
    byteq_t s;
    int d0;
    make_stream(n_words, n_words, 1'b1, s);
    clear_log();
    d0 = done_cnt;
    pulse_start();
    finish_load(s, pct, d0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (wr_addr_q.size() != n_words) begin bad++; $display("FAIL rand_count: got %0d want %0d", wr_addr_q.size(), n_words); end
    for (int k = 0; k < n_words && k < wr_addr_q.size(); k++) begin
      total++; if (wr_addr_q[k] !== AW'(k)) begin bad++; $display("FAIL rand_addr%0d: got %0d want %0d", k, wr_addr_q[k], k); end
      total++; if (wr_data_q[k] !== model_word(s, k)) begin bad++; $display("FAIL rand_data%0d: got %h want %h", k, wr_data_q[k], model_word(s, k)); end
    end
    total++; if (cpu_hold !== model_err(s)) begin bad++; $display("FAIL rand_hold: got %b want %b", cpu_hold, model_err(s)); end
    $display("test_random_valid: N=%0d pct=%0d writes=%0d", n_words, pct, wr_addr_q.size());
  endtask

  task automatic test_reset_mid_load();
    byteq_t s;
    byteq_t part;
    int d0;
    make_stream(4, 4, 1'b1, s);
    part = {};
    for (int i = 0; i < 7; i++) part.push_back(s[i]);
    clear_log();
    d0 = done_cnt;
    pulse_start();
    send_bytes(part, 100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (mem_we !== 1'b0)     begin bad++; $display("FAIL mid_mem_we: got %b want 0", mem_we); end
    total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    total++; if (cpu_hold !== 1'b0)   begin bad++; $display("FAIL mid_hold: got %b want 0", cpu_hold); end
    total++; if (mem_wdata !== 32'd0) begin bad++; $display("FAIL mid_wdata: got %h want 0", mem_wdata); end
    total++; if (mem_addr !== '0)     begin bad++; $display("FAIL mid_addr: got %0d want 0", mem_addr); end
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL mid_count: got %0d want 1", wr_addr_q.size()); end
    if (wr_addr_q.size() >= 1) begin
      total++; if (wr_data_q[0] !== model_word(s, 0)) begin bad++; $display("FAIL mid_data0: got %h want %h", wr_data_q[0], model_word(s, 0)); end
    end
    total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d want %0d", done_cnt, d0); end
    $display("test_reset_mid_load: writes=%0d", wr_addr_q.size());
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byteq_t s;
    int d0;
    logic [7:0] chks [2] = '{8'h12, 8'h00};
    foreach (chks[j]) begin
      s = {8'd1, 8'h13, 8'h00, 8'h00, 8'h00, chks[j]};
      clear_log();
      d0 = done_cnt;
      pulse_start();
      finish_load(s, 100, d0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL chk%0d_count: got %0d want 1", j, wr_addr_q.size()); end
      total++; if (done_err !== model_err(s)) begin bad++; $display("FAIL chk%0d_err: got %b want %b", j, done_err, model_err(s)); end
      total++; if (cpu_hold !== model_err(s)) begin bad++; $display("FAIL chk%0d_hold: got %b want %b", j, cpu_hold, model_err(s)); end
      $display("test_checksum: chk=%h err=%b hold=%b", chks[j], err, cpu_hold);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_not_ready();
    test_single_word();
    test_back_to_back();
    test_bad_len();
    test_random_valid(2, 40);
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_random_valid(5, 70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
